// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: loader state encoding, end-of-program marker,
// and the word geometry also used by the data-memory dump FSM.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          ADDR_STEP      = 4;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bundle between the debug control side and the instruction-memory loader.
//
// Handshake semantics: there is no back-pressure anywhere. i_start and
// i_rx_done are single-cycle strobes; i_rx_data is valid only while i_rx_done
// is high. o_WriteDebug is a one-cycle pulse; o_DirecDebug and o_DatoDebug are
// already stable the cycle before the pulse and stay unchanged during it.
// o_state mirrors the loader FSM for observation only.
interface instr_mem_loader_if #(
  parameter int NBITS = 32
);
  import debug_pkg::*;

  logic             i_start;
  logic [7:0]       i_rx_data;
  logic             i_rx_done;
  logic [NBITS-1:0] o_DirecDebug;
  logic [NBITS-1:0] o_DatoDebug;
  logic             o_WriteDebug;
  logic             o_loading;
  logic             o_done;
  logic             o_overflow;
  logic [NBITS-1:0] o_word_count;
  state_t           o_state;

  // Debug control / UART side
  modport master (
    output i_start, i_rx_data, i_rx_done,
    input  o_DirecDebug, o_DatoDebug, o_WriteDebug, o_loading, o_done,
           o_overflow, o_word_count, o_state
  );

  // Loader side
  modport slave (
    input  i_start, i_rx_data, i_rx_done,
    output o_DirecDebug, o_DatoDebug, o_WriteDebug, o_loading, o_done,
           o_overflow, o_word_count, o_state
  );

endinterface

// File: rtl/byte_word_assembler.sv
// Big-endian byte-to-word assembler with a one-byte holding register for
// bytes that arrive while the loader is busy writing the previous word.
module byte_word_assembler
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,       // drop partial word and any held byte
  input  logic        accept,      // loader is collecting bytes
  input  logic        hold,        // loader busy: park an incoming byte
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        word_valid,  // combinational: 4th byte taken this cycle
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift;
  logic [1:0]  byte_cnt;
  logic [7:0]  pend_data;
  logic        pend_valid;
  logic        take;
  logic [7:0]  take_byte;

  // Select the byte consumed this cycle; a held byte goes first.
  always_comb begin
    take      = 1'b0;
    take_byte = rx_data;
    if (accept) begin
      if (pend_valid) begin
        take      = 1'b1;
        take_byte = pend_data;
      end else if (rx_done) begin
        take      = 1'b1;
      end
    end
  end

  assign word_valid = take && (byte_cnt == LAST_BYTE);
  assign word       = {shift, take_byte};

  // Shift register, byte counter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      byte_cnt   <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
    end else if (flush) begin
      shift      <= '0;
      byte_cnt   <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (take) begin
        shift    <= {shift[15:0], take_byte};
        byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
      end
      if (accept) begin
        // A fresh strobe that collides with draining the held byte is parked.
        if (pend_valid) begin
          pend_valid <= rx_done;
          if (rx_done) pend_data <= rx_data;
        end
      end else if (hold && rx_done) begin
        pend_data  <= rx_data;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from the debug UART byte stream into instruction memory
// through its debug write port, stopping on the halt word or when full.
module instr_mem_loader #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 256,
  parameter logic [NBITS-1:0] HALT_WORD = debug_pkg::HALT_WORD
) (
  input logic                i_clk,
  input logic                i_reset,
  instr_mem_loader_if.slave  bus
);
  import debug_pkg::*;

  localparam logic [NBITS-1:0] STEP      = NBITS'(ADDR_STEP);
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - ADDR_STEP);

  state_t           state;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] data;
  logic [NBITS-1:0] word_count;
  logic             write;
  logic             loading;
  logic             done;
  logic             overflow;

  logic             start_ok;
  logic             is_halt;
  logic             is_full;
  logic             flush;
  logic             word_valid;
  logic [31:0]      asm_word;

  // Decisions that both the FSM and the assembler need this cycle.
  always_comb begin
    start_ok = bus.i_start && ((state == ST_IDLE) || (state == ST_DONE));
    is_halt  = (data == HALT_WORD);
    is_full  = (addr + STEP) > LAST_ADDR;
    flush    = start_ok || ((state == ST_WRITE) && (is_halt || is_full));
  end

  byte_word_assembler u_asm (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .flush      (flush),
    .accept     (state == ST_RECV),
    .hold       ((state == ST_SETUP) || (state == ST_WRITE)),
    .rx_data    (bus.i_rx_data),
    .rx_done    (bus.i_rx_done),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      data       <= '0;
      word_count <= '0;
      write      <= 1'b0;
      loading    <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      write <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state      <= ST_RECV;
            addr       <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            loading    <= 1'b1;
          end
        end
        ST_RECV: begin
          if (word_valid) begin
            data  <= NBITS'(asm_word);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          write      <= 1'b1;
          word_count <= word_count + NBITS'(1);
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (is_halt) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            loading  <= 1'b0;
            overflow <= 1'b0;
          end else if (is_full) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            loading  <= 1'b0;
            overflow <= 1'b1;
          end else begin
            addr  <= addr + STEP;
            state <= ST_RECV;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_DirecDebug = addr;
  assign bus.o_DatoDebug  = data;
  assign bus.o_WriteDebug = write;
  assign bus.o_loading    = loading;
  assign bus.o_done       = done;
  assign bus.o_overflow   = overflow;
  assign bus.o_word_count = word_count;
  assign bus.o_state      = state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: one full-size instance and one 16-cell instance
// sharing the same stimulus, checked against a word-level program model.
module tb_instr_mem_loader;
  import debug_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  instr_mem_loader_if #(.NBITS(32)) bus_a ();
  instr_mem_loader_if #(.NBITS(32)) bus_b ();

  assign bus_a.i_start   = start;
  assign bus_a.i_rx_data = rx_data;
  assign bus_a.i_rx_done = rx_done;
  assign bus_b.i_start   = start;
  assign bus_b.i_rx_data = rx_data;
  assign bus_b.i_rx_done = rx_done;

  instr_mem_loader #(.NBITS(32), .CELDAS(256)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_a));
  instr_mem_loader #(.NBITS(32), .CELDAS(16)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_b));

  // ---------------- write monitor ----------------
  logic [31:0] obs_addr_a[$];
  logic [31:0] obs_data_a[$];
  logic [31:0] obs_addr_b[$];
  logic [31:0] obs_data_b[$];
  int          dbl_pulse = 0;
  logic        prev_wr_a = 1'b0;
  logic        prev_wr_b = 1'b0;

  always @(negedge clk) begin
    if (bus_a.o_WriteDebug) begin
      obs_addr_a.push_back(bus_a.o_DirecDebug);
      obs_data_a.push_back(bus_a.o_DatoDebug);
    end
    if (bus_b.o_WriteDebug) begin
      obs_addr_b.push_back(bus_b.o_DirecDebug);
      obs_data_b.push_back(bus_b.o_DatoDebug);
    end
    if (bus_a.o_WriteDebug && prev_wr_a) dbl_pulse++;
    if (bus_b.o_WriteDebug && prev_wr_b) dbl_pulse++;
    prev_wr_a = bus_a.o_WriteDebug;
    prev_wr_b = bus_b.o_WriteDebug;
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];
  int          exp_count;
  bit          exp_overflow;
  bit          exp_done;

  // Program-level view: bytes form big-endian words written at 4*index;
  // the halt word is written then ends the load, and the load also ends
  // once the last cell (celdas-4) has been written.
  task automatic model_load(input logic [7:0] bytes[$], input int celdas);
    exp_addr_q.delete();
    exp_q.delete();
    exp_count    = 0;
    exp_overflow = 1'b0;
    exp_done     = 1'b0;
    for (int i = 0; i + 3 < bytes.size(); i += 4) begin
      logic [31:0] w;
      if (exp_done) break;
      w = {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
      exp_addr_q.push_back(32'(i));
      exp_q.push_back(w);
      exp_count++;
      if (w == 32'hFFFF_FFFF) exp_done = 1'b1;
      else if ((i / 4 + 1) * 4 >= celdas) begin
        exp_done     = 1'b1;
        exp_overflow = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_addr_a.delete(); obs_data_a.delete();
    obs_addr_b.delete(); obs_data_b.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Strobes are at least two cycles apart, as a real UART guarantees.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic push_word(inout logic [7:0] bytes[$], input logic [31:0] w);
    bytes.push_back(w[31:24]); bytes.push_back(w[23:16]);
    bytes.push_back(w[15:8]);  bytes.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  task automatic wait_done(input bit on_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (on_b ? bus_b.o_done : bus_a.o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.o_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", bus_a.o_state, ST_IDLE);
    end
    checks++;
    if ({bus_a.o_WriteDebug, bus_a.o_loading, bus_a.o_done, bus_a.o_overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000",
        {bus_a.o_WriteDebug, bus_a.o_loading, bus_a.o_done, bus_a.o_overflow});
    end
    checks++;
    if ({bus_a.o_DirecDebug, bus_a.o_DatoDebug, bus_a.o_word_count} !== 96'h0) begin
      errors++; $display("FAIL reset_buses got=%h/%h/%h exp=0",
        bus_a.o_DirecDebug, bus_a.o_DatoDebug, bus_a.o_word_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed_program();
    logic [7:0] bytes[$];
    logic [31:0] want_a[3];
    logic [31:0] want_d[3];
    bit ok;
    apply_reset();
    bytes = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h80, 8'h44, 8'h00, 8'h01,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    want_a = '{32'd0, 32'd4, 32'd8};
    want_d = '{32'h0022_0820, 32'h8044_0001, 32'hFFFF_FFFF};
    pulse_start();
    send_bytes(bytes);
    wait_done(1'b0, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL directed_timeout got=not_done exp=done"); end
    checks++;
    if (obs_addr_a.size() != 3) begin
      errors++; $display("FAIL directed_nwrites got=%0d exp=3", obs_addr_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_addr_a[i] !== want_a[i] || obs_data_a[i] !== want_d[i]) begin
          errors++; $display("FAIL directed_write%0d got=%h:%h exp=%h:%h",
            i, obs_addr_a[i], obs_data_a[i], want_a[i], want_d[i]);
        end
      end
    end
    checks++;
    if (bus_a.o_done !== 1'b1 || bus_a.o_overflow !== 1'b0 || bus_a.o_word_count !== 32'd3 ||
        bus_a.o_loading !== 1'b0) begin
      errors++; $display("FAIL directed_end got=done%b ovf%b cnt%0d ld%b exp=done1 ovf0 cnt3 ld0",
        bus_a.o_done, bus_a.o_overflow, bus_a.o_word_count, bus_a.o_loading);
    end
  endtask

  task automatic test_random_programs();
    for (int t = 0; t < 3; t++) begin
      logic [7:0] bytes[$];
      int nw;
      bit ok;
      apply_reset();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) push_word(bytes, rand_word());
      push_word(bytes, 32'hFFFF_FFFF);
      model_load(bytes, 256);
      pulse_start();
      send_bytes(bytes);
      wait_done(1'b0, 50, ok);
      checks++;
      if (!ok || obs_addr_a.size() != exp_count) begin
        errors++; $display("FAIL random%0d_nwrites got=%0d done=%0b exp=%0d",
          t, obs_addr_a.size(), ok, exp_count);
      end else begin
        for (int i = 0; i < exp_count; i++) begin
          checks++;
          if (obs_addr_a[i] !== exp_addr_q[i] || obs_data_a[i] !== exp_q[i]) begin
            errors++; $display("FAIL random%0d_write%0d got=%h:%h exp=%h:%h",
              t, i, obs_addr_a[i], obs_data_a[i], exp_addr_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (bus_a.o_word_count !== 32'(exp_count) || bus_a.o_overflow !== exp_overflow) begin
        errors++; $display("FAIL random%0d_end got=cnt%0d ovf%b exp=cnt%0d ovf%b",
          t, bus_a.o_word_count, bus_a.o_overflow, exp_count, exp_overflow);
      end
    end
  endtask

  task automatic test_timing();
    logic [31:0] w;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [7:0]  halt_bytes[$];
    bit ok;
    apply_reset();
    w = rand_word();
    pulse_start();
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]);
    @(negedge clk); rx_data = w[7:0]; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    a0 = bus_a.o_DirecDebug;
    d0 = bus_a.o_DatoDebug;
    checks++;
    if (bus_a.o_state !== ST_SETUP || bus_a.o_WriteDebug !== 1'b0 || d0 !== w) begin
      errors++; $display("FAIL timing_setup got=st%0d wr%b data%h exp=st%0d wr0 data%h",
        bus_a.o_state, bus_a.o_WriteDebug, d0, ST_SETUP, w);
    end
    @(negedge clk);
    checks++;
    if (bus_a.o_WriteDebug !== 1'b1) begin
      errors++; $display("FAIL timing_latency got=wr%b exp=wr1", bus_a.o_WriteDebug);
    end
    checks++;
    if (bus_a.o_DirecDebug !== a0 || bus_a.o_DatoDebug !== d0 || a0 !== 32'd0) begin
      errors++; $display("FAIL timing_stable got=%h:%h exp=%h:%h",
        bus_a.o_DirecDebug, bus_a.o_DatoDebug, 32'd0, d0);
    end
    @(negedge clk);
    checks++;
    if (bus_a.o_WriteDebug !== 1'b0 || bus_a.o_state !== ST_RECV) begin
      errors++; $display("FAIL timing_width got=wr%b st%0d exp=wr0 st%0d",
        bus_a.o_WriteDebug, bus_a.o_state, ST_RECV);
    end
    push_word(halt_bytes, 32'hFFFF_FFFF);
    send_bytes(halt_bytes);
    wait_done(1'b0, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timing_done got=not_done exp=done"); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[$];
    bit ok;
    apply_reset();
    for (int k = 0; k < 5; k++) push_word(bytes, rand_word());
    model_load(bytes, 16);
    pulse_start();
    send_bytes(bytes);
    wait_done(1'b1, 50, ok);
    checks++;
    if (!ok || obs_addr_b.size() != 4) begin
      errors++; $display("FAIL overflow_nwrites got=%0d done=%0b exp=4", obs_addr_b.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_addr_b[i] !== exp_addr_q[i] || obs_data_b[i] !== exp_q[i] ||
            obs_addr_b[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL overflow_write%0d got=%h:%h exp=%h:%h",
            i, obs_addr_b[i], obs_data_b[i], exp_addr_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus_b.o_overflow !== 1'b1 || exp_overflow !== 1'b1 || bus_b.o_word_count !== 32'd4 ||
        bus_b.o_DirecDebug !== 32'd12) begin
      errors++; $display("FAIL overflow_end got=ovf%b cnt%0d addr%0d exp=ovf1 cnt4 addr12",
        bus_b.o_overflow, bus_b.o_word_count, bus_b.o_DirecDebug);
    end
  endtask

  task automatic test_pending();
    logic [31:0] w1;
    logic [31:0] w2;
    logic [7:0]  rest[$];
    logic [7:0]  all[$];
    bit ok;
    apply_reset();
    w1 = rand_word();
    w2 = {8'hAB, 24'($urandom)};
    push_word(all, w1); push_word(all, w2); push_word(all, 32'hFFFF_FFFF);
    model_load(all, 256);
    pulse_start();
    send_byte(w1[31:24]); send_byte(w1[23:16]); send_byte(w1[15:8]);
    @(negedge clk); rx_data = w1[7:0]; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_a.o_state !== ST_WRITE) begin
      errors++; $display("FAIL pending_in_write got=st%0d exp=st%0d", bus_a.o_state, ST_WRITE);
    end
    rx_data = 8'hAB; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    rest = '{w2[23:16], w2[15:8], w2[7:0], 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(rest);
    wait_done(1'b0, 50, ok);
    checks++;
    if (!ok || obs_data_a.size() != 3) begin
      errors++; $display("FAIL pending_nwrites got=%0d done=%0b exp=3", obs_data_a.size(), ok);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_addr_a[i] !== exp_addr_q[i] || obs_data_a[i] !== exp_q[i]) begin
          errors++; $display("FAIL pending_write%0d got=%h:%h exp=%h:%h",
            i, obs_addr_a[i], obs_data_a[i], exp_addr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w1;
    logic [31:0] w2;
    logic [7:0]  b1[$];
    logic [7:0]  b2[$];
    apply_reset();
    w1 = rand_word();
    w2 = rand_word();
    push_word(b1, w1);
    b1.push_back(8'h5A); b1.push_back(8'hC3);
    push_word(b2, w2);
    pulse_start();
    send_bytes(b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.o_state !== ST_IDLE || bus_a.o_loading !== 1'b0 || bus_a.o_word_count !== 32'd0 ||
        bus_a.o_DirecDebug !== 32'd0 || bus_a.o_DatoDebug !== 32'd0) begin
      errors++; $display("FAIL async_reset got=st%0d ld%b cnt%0d addr%h data%h exp=all0",
        bus_a.o_state, bus_a.o_loading, bus_a.o_word_count, bus_a.o_DirecDebug, bus_a.o_DatoDebug);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_addr_a.delete(); obs_data_a.delete();
    obs_addr_b.delete(); obs_data_b.delete();
    pulse_start();
    send_bytes(b2);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_addr_a.size() != 1 || obs_addr_a[0] !== 32'd0 || obs_data_a[0] !== w2) begin
      errors++; $display("FAIL async_reload got=n%0d first=%h exp=n1 0:%h",
        obs_addr_a.size(), (obs_data_a.size() > 0) ? obs_data_a[0] : 32'hx, w2);
    end
    checks++;
    if (bus_a.o_word_count !== 32'd1 || bus_a.o_loading !== 1'b1) begin
      errors++; $display("FAIL async_reload_cnt got=cnt%0d ld%b exp=cnt1 ld1",
        bus_a.o_word_count, bus_a.o_loading);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] w;
    logic [7:0]  junk[$];
    logic [7:0]  halt_bytes[$];
    bit ok;
    apply_reset();
    for (int k = 0; k < 4; k++) junk.push_back(8'($urandom));
    send_bytes(junk);
    checks++;
    if (bus_a.o_state !== ST_IDLE || obs_addr_a.size() != 0 || bus_a.o_word_count !== 32'd0) begin
      errors++; $display("FAIL ignore_idle got=st%0d n%0d cnt%0d exp=st0 n0 cnt0",
        bus_a.o_state, obs_addr_a.size(), bus_a.o_word_count);
    end
    w = rand_word();
    pulse_start();
    send_byte(w[31:24]);
    pulse_start();
    checks++;
    if (bus_a.o_state !== ST_RECV) begin
      errors++; $display("FAIL ignore_start_state got=st%0d exp=st%0d", bus_a.o_state, ST_RECV);
    end
    send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    push_word(halt_bytes, 32'hFFFF_FFFF);
    send_bytes(halt_bytes);
    wait_done(1'b0, 50, ok);
    checks++;
    if (!ok || obs_data_a.size() != 2 || obs_data_a[0] !== w) begin
      errors++; $display("FAIL ignore_start_word got=n%0d first=%h exp=n2 first=%h",
        obs_data_a.size(), (obs_data_a.size() > 0) ? obs_data_a[0] : 32'hx, w);
    end
    send_bytes(junk);
    checks++;
    if (bus_a.o_state !== ST_DONE || obs_addr_a.size() != 2 || bus_a.o_word_count !== 32'd2 ||
        bus_a.o_DirecDebug !== 32'd4 || bus_a.o_done !== 1'b1) begin
      errors++; $display("FAIL ignore_done got=st%0d n%0d cnt%0d addr%0d done%b exp=st%0d n2 cnt2 addr4 done1",
        bus_a.o_state, obs_addr_a.size(), bus_a.o_word_count, bus_a.o_DirecDebug, bus_a.o_done, ST_DONE);
    end
  endtask

  task automatic test_pulse_width();
    checks++;
    if (dbl_pulse != 0) begin
      errors++; $display("FAIL pulse_width got=%0d double pulses exp=0", dbl_pulse);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed_program();
    test_random_programs();
    test_timing();
    test_overflow();
    test_pending();
    test_async_reset();
    test_ignored();
    test_pulse_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Debug-side writer for the instruction memory's debug write port (address, data, write strobe).
- Assembles a byte stream from the debug UART receiver into 32-bit instruction words.
- Presents each word with its byte address, then issues one write pulse per word.
- Stops on the halt word 0xFFFFFFFF or when the memory is full, and reports completion to the debug control FSM.

Parameters:
- NBITS, 32, instruction/data/address width
- CELDAS, 256, memory cells; valid write addresses 0..CELDAS-4, step 4
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker (written, then load ends)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse: begin a new program load
- i_rx_data  in  8  byte from UART receiver
- i_rx_done  in  1  one-cycle strobe: i_rx_data valid
- o_DirecDebug  out  NBITS  byte address to instruction memory
- o_DatoDebug  out  NBITS  instruction word to instruction memory
- o_WriteDebug  out  1  write pulse; memory captures on its rising edge
- o_loading  out  1  high from start accepted until DONE
- o_done  out  1  load finished (halt word written or memory full)
- o_overflow  out  1  load ended because the address space was exhausted, not by halt
- o_word_count  out  NBITS  words written in the current or last load

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE immediately.
  - All outputs go to 0; byte counter, shift register and pending flag are cleared.
  - Reset mid-load abandons the partial word; the memory keeps the words already written.
- State encoding: 3 bits. States IDLE, RECV, SETUP, WRITE, DONE.
- IDLE:
  - i_rx_done is ignored.
  - i_start -> RECV. On the transition: address=0, byte_cnt=0, word_count=0, o_done=0, o_overflow=0, o_loading=1.
- RECV:
  - On each i_rx_done: shift = {shift[23:0], i_rx_data}. The first byte received is the MSB (big-endian). byte_cnt increments.
  - When the 4th byte is captured: load o_DatoDebug with the assembled word, byte_cnt=0, -> SETUP.
  - i_start while in RECV is ignored.
- SETUP:
  - o_DirecDebug and o_DatoDebug are stable and o_WriteDebug=0. This guarantees one full cycle of setup before the rising edge.
  - Next cycle -> WRITE.
- WRITE:
  - o_WriteDebug=1 for exactly one cycle; word_count increments.
  - Next cycle o_WriteDebug=0, and the next state is chosen by the first matching rule:
    - word == HALT_WORD -> DONE, o_overflow=0.
    - address+4 > CELDAS-4 -> DONE, o_overflow=1.
    - otherwise address += 4, -> RECV.
- Byte arriving during SETUP or WRITE:
  - Held in a 1-byte pending register with a pending flag.
  - On re-entering RECV it is consumed in the first cycle as if i_rx_done had fired.
  - A second byte while pending is set overwrites the pending byte (UART byte spacing makes this unreachable in practice). The bench flags it as an error case only.
  - Pending is discarded if the next state is DONE.
- DONE:
  - o_done=1 and o_loading=0; o_DirecDebug, o_DatoDebug and o_word_count hold their last values.
  - i_rx_done is ignored.
  - i_start -> RECV with full re-init as from IDLE.
- Latency: the 4th byte strobe at cycle n gives SETUP at n+1, o_WriteDebug high at n+2, and RECV or DONE at n+3.
- o_WriteDebug is registered and glitch-free; it is never high in two consecutive cycles.

Decomposition:
- Shared package `debug_pkg`:
  - State encoding constants (ST_IDLE..ST_DONE).
  - HALT_WORD.
  - BYTES_PER_WORD=4 and ADDR_STEP=4, both shared with the debug unit's data-memory dump FSM.
- One sub-module, `byte_word_assembler`:
  - Shift register and byte counter.
  - Pending-byte holding register.
  - Outputs word_valid and word.
- The FSM and address/count logic stay in instr_mem_loader.

Test Plan:
- Reset, start, then bytes 00 22 08 20, 80 44 00 01, FF FF FF FF:
  - Three write pulses: addr 0 data 0x00220820, addr 4 data 0x80440001, addr 8 data 0xFFFFFFFF.
  - Then o_done=1, o_overflow=0, o_word_count=3.
- Timing of one word: check the data/address values at the o_WriteDebug rising edge equal their values one cycle earlier. Check the pulse width is exactly 1 cycle and the 4th-byte-to-pulse latency is 2 cycles.
- CELDAS=16 and 5 non-halt words:
  - Writes at addr 0, 4, 8, 12, then DONE with o_overflow=1 and o_word_count=4.
  - The 5th word's bytes are ignored.
- Byte strobe injected in the WRITE cycle (first byte of the next word 0xAB):
  - The next written word's MSB is 0xAB and no byte is lost.
- Reset pulse (i_reset=0) asynchronously after 2 bytes of word 2:
  - Outputs go to 0 immediately with no clock edge and the state is IDLE.
  - A new i_start and 4 bytes write at addr 0.
- i_rx_done in IDLE and DONE, and i_start during RECV: no writes, no state change, counters unchanged.
